// File: rtl/serial_add_seq.sv
// Purpose: bit-serial WIDTH-bit adder sequencer driving an external one-bit full adder, LSB first.
// Latency: o_done pulses in the cycle after the WIDTH-th edge following the start-accept edge.
// Backpressure: none; i_start is only sampled in IDLE and ignored while o_busy is high.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_start              start request, accepted only in IDLE
//   i_a, i_b, i_cin      operands and carry-in, captured on the accept edge
//   o_bit1, o_bit2       current A / B bit to the external adder (0 outside SHIFT)
//   o_carry              registered carry to the external adder (0 outside SHIFT)
//   i_sum, i_carry       combinational sum / carry-out returned by the external adder
//   o_busy               high in SHIFT and DONE
//   o_done               one-cycle pulse when o_sum / o_cout are valid
//   o_sum, o_cout        result; held from DONE until the next accepted start
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_bit1,
  output logic             o_bit2,
  output logic             o_carry,
  input  logic             i_sum,
  input  logic             i_carry,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Counter only needs to reach WIDTH-1; the last SHIFT edge is detected at that value.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             shift_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_b;
            carry_q <= i_cin;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            shift_q <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
          sum_q   <= {i_sum, sum_q[WIDTH-1:1]};
          carry_q <= i_carry;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            shift_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          shift_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // carry_q keeps the final carry after SHIFT (it is o_cout), so the adder-facing
  // bits are gated by the registered SHIFT flag rather than relying on register contents.
  assign o_bit1  = shift_q & a_q[0];
  assign o_bit2  = shift_q & b_q[0];
  assign o_carry = shift_q & carry_q;

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_sum   = sum_q;
  assign o_cout  = carry_q;

  // Structural invariants of the sequencer.
  a_done_implies_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_done |-> o_busy);
  a_done_single_cycle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_done |=> !o_done);
  a_shift_implies_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    shift_q |-> busy_q);

endmodule

// File: tb/tb_serial_add_seq.sv
// Purpose: directed self-checking bench for serial_add_seq with a behavioural one-bit adder in the loop.
// Latency: expects o_done exactly WIDTH edges after the accept edge, lasting one cycle.
// Backpressure: exercises ignored starts while busy and back-to-back held starts.
module tb_serial_add_seq;

  localparam int WIDTH = 8;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_bit1;
  logic             o_bit2;
  logic             o_carry;
  logic             i_sum;
  logic             i_carry;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

  int checks;
  int errors;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_bit1  (o_bit1),
    .o_bit2  (o_bit2),
    .o_carry (o_carry),
    .i_sum   (i_sum),
    .i_carry (i_carry),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_cout  (o_cout)
  );

  // External one-bit full adder closing the loop.
  assign i_sum   = o_bit1 ^ o_bit2 ^ o_carry;
  assign i_carry = (o_bit1 & o_bit2) | (o_bit1 & o_carry) | (o_bit2 & o_carry);

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    bit         garble;   // scramble operands right after the accept edge
    int         pulse_k;  // cycle index at which to raise a stray start (-1: none)
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Runs one addition; k counts rising edges after the accept edge (k=0 is the accept edge).
  task automatic do_add(input vec_t v, input string tag);
    logic       c;
    bit         stream_ok;
    bit         busy_ok;
    int         ndone;
    int         first_done;
    logic [7:0] sum_at_done;
    logic       cout_at_done;
    stream_ok    = 1'b1;
    busy_ok      = 1'b1;
    ndone        = 0;
    first_done   = -1;
    sum_at_done  = '0;
    cout_at_done = 1'b0;
    c            = v.cin;

    @(negedge i_clk);
    i_start = 1'b1;
    i_a     = v.a;
    i_b     = v.b;
    i_cin   = v.cin;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    if (v.garble) begin
      i_a   = ~v.a;
      i_b   = ~v.b;
      i_cin = ~v.cin;
    end

    for (int k = 0; k < 20; k++) begin
      if (k < WIDTH) begin
        if (o_bit1 !== v.a[k] || o_bit2 !== v.b[k] || o_carry !== c) stream_ok = 1'b0;
        c = maj(v.a[k], v.b[k], c);
      end else begin
        if (o_bit1 !== 1'b0 || o_bit2 !== 1'b0 || o_carry !== 1'b0) stream_ok = 1'b0;
      end
      if (o_busy !== ((k <= WIDTH) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      if (o_done === 1'b1) begin
        ndone++;
        if (first_done < 0) begin
          first_done   = k;
          sum_at_done  = o_sum;
          cout_at_done = o_cout;
        end
      end
      if (k == v.pulse_k) begin
        i_start = 1'b1;
        i_a     = 8'hFF;
      end
      if (k == v.pulse_k + 2) i_start = 1'b0;
      @(posedge i_clk);
      #1;
    end

    chk({tag, "_latency"}, first_done, WIDTH);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_bit_stream"}, {31'd0, stream_ok}, 1);
    chk({tag, "_busy_profile"}, {31'd0, busy_ok}, 1);
    chk({tag, "_sum_at_done"}, {24'd0, sum_at_done}, {24'd0, v.exp_sum});
    chk({tag, "_cout_at_done"}, {31'd0, cout_at_done}, {31'd0, v.exp_cout});
    chk({tag, "_sum_held"}, {24'd0, o_sum}, {24'd0, v.exp_sum});
    chk({tag, "_cout_held"}, {31'd0, o_cout}, {31'd0, v.exp_cout});
  endtask

  function automatic logic [31:0] all_outs();
    return {20'd0, o_busy, o_done, o_sum, o_cout, o_bit1, o_bit2, o_carry};
  endfunction

  initial begin
    int ndone;
    int first_done;
    int second_done;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, -1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, -1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, -1};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0,  3};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b1, -1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, -1};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, -1};
    vecs[9] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0, 1'b0, -1};

    // Reset state, including a start held high while reset is asserted.
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_cin   = 1'b0;
    #3;
    chk("reset_outputs", all_outs(), 32'd0);
    i_start = 1'b1;
    i_a     = 8'h3C;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_ignores_start", all_outs(), 32'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    i_rst_n = 1'b1;

    foreach (vecs[i]) do_add(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of SHIFT: everything clears at once and no done follows.
    @(negedge i_clk);
    i_start = 1'b1;
    i_a     = 8'hAA;
    i_b     = 8'h55;
    i_cin   = 1'b0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #2;
    chk("pre_reset_busy", {31'd0, o_busy}, 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs(), 32'd0);
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge i_clk);
      #1;
      if (o_done === 1'b1) ndone++;
      if (k == 1) begin
        @(negedge i_clk);
        i_rst_n = 1'b1;
      end
    end
    chk("mid_reset_no_done", ndone, 0);
    chk("mid_reset_idle", all_outs(), 32'd0);
    do_add('{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1}, "post_reset");

    // Back-to-back: start held high; second accept on the first IDLE edge after DONE.
    @(negedge i_clk);
    i_start = 1'b1;
    i_a     = 8'h3C;
    i_b     = 8'h0F;
    i_cin   = 1'b0;
    @(posedge i_clk);
    #1;
    ndone       = 0;
    first_done  = -1;
    second_done = -1;
    for (int k = 0; k < 22; k++) begin
      if (o_done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) begin
          second_done = k;
          chk("b2b_second_sum", {24'd0, o_sum}, 32'h03);
          chk("b2b_second_cout", {31'd0, o_cout}, 0);
        end
      end
      if (k == 9) begin
        chk("b2b_idle_gap_busy", {31'd0, o_busy}, 0);
        chk("b2b_sum_held", {24'd0, o_sum}, 32'h4B);
        i_a = 8'h01;
        i_b = 8'h02;
      end
      if (k == 10) begin
        chk("b2b_reaccept_busy", {31'd0, o_busy}, 1);
        i_start = 1'b0;
      end
      @(posedge i_clk);
      #1;
    end
    chk("b2b_first_done", first_done, 8);
    chk("b2b_second_done", second_done, 18);
    chk("b2b_done_count", ndone, 2);
    chk("b2b_final_sum_held", {24'd0, o_sum}, 32'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port i_clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous reset, active low.
REQ-005 SHALL have port i_start, input, 1 bit: request to start an addition, sampled on the rising edge.
REQ-006 SHALL have port i_a, input, WIDTH bits: operand A, captured on the accepted start.
REQ-007 SHALL have port i_b, input, WIDTH bits: operand B, captured on the accepted start.
REQ-008 SHALL have port i_cin, input, 1 bit: carry-in, captured on the accepted start.
REQ-009 SHALL have port o_bit1, output, 1 bit: current A bit driven to the external one-bit adder.
REQ-010 SHALL have port o_bit2, output, 1 bit: current B bit driven to the external one-bit adder.
REQ-011 SHALL have port o_carry, output, 1 bit: registered carry driven to the adder carry input.
REQ-012 SHALL have port i_sum, input, 1 bit: sum bit returned by the adder (combinational, same cycle).
REQ-013 SHALL have port i_carry, input, 1 bit: carry-out returned by the adder (combinational, same cycle).
REQ-014 SHALL have port o_busy, output, 1 bit: high while an addition is in progress.
REQ-015 SHALL have port o_done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-016 SHALL have port o_sum, output, WIDTH bits: result sum.
REQ-017 SHALL have port o_cout, output, 1 bit: result carry-out.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-019 In IDLE, with i_start=1 at a rising edge, SHALL capture i_a, i_b and i_cin (carry register <= i_cin), clear o_sum, clear the bit counter, and go to SHIFT.
REQ-020 In SHIFT, SHALL drive o_bit1=A_reg[0], o_bit2=B_reg[0] and o_carry=carry register, all LSB-first.
REQ-021 On each SHIFT edge, SHALL shift right as follows: sum_reg <= {i_sum, sum_reg[WIDTH-1:1]}, carry register <= i_carry, A_reg and B_reg shift right by one, and the counter increments.
REQ-022 After exactly WIDTH SHIFT cycles, SHALL enter DONE; o_sum=sum_reg and o_cout=carry register.
REQ-023 In DONE, SHALL assert o_done for exactly one cycle, then return to IDLE unconditionally.
REQ-024 o_done SHALL first be high in the cycle after the WIDTH-th edge following the start-accept edge.
REQ-025 o_busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-026 o_bit1, o_bit2 and o_carry SHALL be 0 outside SHIFT.
REQ-027 i_start SHALL be ignored in SHIFT and DONE, with no restart and no corruption of the operation in progress.
REQ-028 o_sum and o_cout SHALL hold their value from DONE until the next accepted start.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH; overflow SHALL appear only on o_cout, and o_cout SHALL equal bit WIDTH of i_a+i_b+i_cin.
REQ-030 i_a, i_b and i_cin changing after the accept edge SHALL NOT affect the result.

Reset
REQ-031 Asserting i_rst_n=0 SHALL immediately force state IDLE, the counter to 0, and all registers to 0.
REQ-032 Under reset, outputs SHALL be o_busy=0, o_done=0, o_sum=0, o_cout=0, o_bit1=0, o_bit2=0 and o_carry=0.
REQ-033 Reset during SHIFT or DONE SHALL discard the partial result; no o_done pulse SHALL follow.
REQ-034 After release, the first rising edge with i_start=1 SHALL be accepted.

Verification (WIDTH=8, bench instantiates Onebitadder on the o_bit*/o_carry/i_sum/i_carry loop)
REQ-035 Stimulus: a=0x3C, b=0x0F, cin=0 -> o_sum=0x4B, o_cout=0, with o_done exactly 8 cycles after the accept edge, lasting 1 cycle.
REQ-036 Stimulus: a=0xFF, b=0x01, cin=0 -> o_sum=0x00, o_cout=1, with carry rippling through all 8 SHIFT cycles.
REQ-037 Stimulus: a=0xFF, b=0x00, cin=1 -> o_sum=0x00, o_cout=1; a=0x00, b=0x00, cin=1 -> o_sum=0x01, o_cout=0.
REQ-038 Stimulus: start 0x12+0x34, then i_start=1 with a=0xFF at cycle 3 -> o_sum=0x46 and only one o_done pulse.
REQ-039 Stimulus: start 0xAA+0x55, then i_rst_n=0 at cycle 4 -> all outputs 0 at once and no o_done; after release, 0x01+0x01 -> o_sum=0x02.
REQ-040 Stimulus: back-to-back starts held high -> second start accepted on the first IDLE edge after DONE, with o_sum held between operations.
